step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 120 ++++++++++++
 tb/tb_step_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Stepper-motor phase sequencer: emits a 2-bit coil-phase index that advances
// once every `period` clocks for `step_count` steps, with abort and done pulse.
module step_sequencer #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] step_count,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic [3:0]       phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q,     state_d;
  logic [1:0]       phase_q,     phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PER_W-1:0] timer_q,     timer_d;
  logic [PER_W-1:0] period_q,    period_d;
  logic             dir_q,       dir_d;

  logic [PER_W-1:0] period_eff;
  logic             step_due;

  assign period_eff = (period == '0) ? PER_W'(1) : period;
  assign step_due   = (timer_q == PER_W'(1));

  // NOTE: every signal driven here gets its hold value first, so no path through
  // the case statement leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    period_d    = period_q;
    dir_d       = dir_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (step_count != '0) begin
            dir_d       = dir;
            period_d    = period_eff;
            timer_d     = period_eff;
            remaining_d = step_count;
            state_d     = S_RUN;
          end else begin
            remaining_d = '0;
            state_d     = S_FIN;
          end
        end
      end

      S_RUN: begin
        // Abort takes priority over a step falling due on the same edge.
        if (abort) begin
          state_d = S_FIN;
        end else if (step_due) begin
          phase_d = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if (remaining_q <= CNT_W'(1)) begin
            timer_d = '0;
            state_d = S_FIN;
          end else begin
            timer_d = period_q;
          end
        end else if (timer_q != '0) begin
          timer_d = timer_q - PER_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      remaining_q <= '0;
      timer_q     <= '0;
      period_q    <= PER_W'(1);
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      dir_q       <= dir_d;
    end
  end

  assign phase     = {2'b00, phase_q};
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FIN);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: stimulus queues expected phase steps and
// done pulses with their cycle stamps; a negedge monitor pops and compares them.
module tb_step_sequencer;

  localparam int CNT_W = 16;
  localparam int PER_W = 16;

  typedef enum int { EV_STEP, EV_DONE } ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       phase;
    int       rem;
    int       cyc;
  } ev_t;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] step_count;
  logic [PER_W-1:0] period;
  logic             abort;
  logic [3:0]       phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  step_sequencer #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dir        (dir),
    .step_count (step_count),
    .period     (period),
    .abort      (abort),
    .phase      (phase),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  ev_t  sb[$];
  ev_t  mon_e;
  logic [3:0] last_phase = 4'd0;
  logic [1:0] mphase = 2'd0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: an output event is a phase change or a done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_phase = phase;
    end else begin
      if (phase != last_phase) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_step", phase, -1);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.kind == EV_STEP, "step_kind", mon_e.kind, EV_STEP);
          check(phase == mon_e.phase, "step_phase", phase, mon_e.phase);
          check(remaining == mon_e.rem, "step_remaining", remaining, mon_e.rem);
          check(cyc == mon_e.cyc, "step_cycle", cyc, mon_e.cyc);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_done", done, 0);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.kind == EV_DONE, "done_kind", mon_e.kind, EV_DONE);
          check(phase == mon_e.phase, "done_phase", phase, mon_e.phase);
          check(remaining == mon_e.rem, "done_remaining", remaining, mon_e.rem);
          check(cyc == mon_e.cyc, "done_cycle", cyc, mon_e.cyc);
          check(busy == 1'b0, "done_busy_excl", busy, 0);
        end
      end
      if (busy) busy_cnt++;
      last_phase = phase;
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One move; abort_after / reset_after < 0 disables that event.
  task automatic do_move(input logic d, input int cnt, input int per,
                         input int abort_after, input int reset_after, input bit mid_start);
    int pe, a, n_ev, done_cyc;
    pe = (per == 0) ? 1 : per;
    @(negedge clk);
    reset_n    = 1'b1;
    start      = 1'b1;
    dir        = d;
    step_count = CNT_W'(cnt);
    period     = PER_W'(per);
    a = cyc + 1;
    n_ev = cnt;
    if (abort_after >= 0) n_ev = abort_after;
    if (reset_after >= 0) n_ev = reset_after;
    for (int k = 1; k <= n_ev; k++) begin
      mphase = d ? mphase + 2'd1 : mphase - 2'd1;
      sb.push_back('{EV_STEP, int'(mphase), cnt - k, a + k * pe});
    end
    done_cyc = (abort_after >= 0) ? a + (abort_after + 1) * pe : a + cnt * pe;
    if (reset_after < 0)
      sb.push_back('{EV_DONE, int'(mphase), cnt - n_ev, done_cyc});
    @(negedge clk);
    start = 1'b0;
    if (mid_start) begin
      @(negedge clk);
      start = 1'b1; step_count = CNT_W'(99); dir = !d; period = PER_W'(1);
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_after >= 0) begin
      wait_cyc(a + (abort_after + 1) * pe - 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    if (reset_after >= 0) begin
      wait_cyc(a + reset_after * pe + 1);
      reset_n = 1'b0;
      mphase  = 2'd0;
      @(negedge clk);
      check(phase == 4'd0, "rst_mid_phase", phase, 0);
      check(busy == 1'b0, "rst_mid_busy", busy, 0);
      check(done == 1'b0, "rst_mid_done", done, 0);
      check(remaining == '0, "rst_mid_remaining", remaining, 0);
    end else begin
      wait_cyc(done_cyc + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int b0;

  initial begin
    reset_n = 1'b0; start = 1'b0; dir = 1'b1; step_count = '0; period = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check(phase == 4'd0, "reset_phase", phase, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(remaining == '0, "reset_remaining", remaining, 0);

    // Forward move, period 4: phases 1,2,3,0,1,2.
    b0 = busy_cnt;
    do_move(1'b1, 6, 4, -1, -1, 1'b0);
    check(busy_cnt - b0 == 24, "fwd_busy_cycles", busy_cnt - b0, 24);
    check(remaining == '0, "fwd_remaining_end", remaining, 0);
    check(phase == 4'd2, "fwd_phase_end", phase, 2);

    // Bring phase back to 0, then reverse wrap 3,2,1 at period 1.
    do_move(1'b1, 2, 3, -1, -1, 1'b0);
    b0 = busy_cnt;
    do_move(1'b0, 3, 1, -1, -1, 1'b0);
    check(busy_cnt - b0 == 3, "rev_busy_cycles", busy_cnt - b0, 3);
    check(phase == 4'd1, "rev_phase_end", phase, 1);

    // Zero-length move: done only, busy never high.
    b0 = busy_cnt;
    do_move(1'b1, 0, 7, -1, -1, 1'b0);
    check(busy_cnt - b0 == 0, "zero_len_busy", busy_cnt - b0, 0);

    // Zero period behaves as one clock per step.
    do_move(1'b1, 2, 0, -1, -1, 1'b0);

    // Abort colliding with the 4th step.
    do_move(1'b1, 10, 5, 3, -1, 1'b0);
    check(remaining == CNT_W'(7), "abort_remaining", remaining, 7);
    check(phase == 4'd2, "abort_phase", phase, 2);

    // Abort while idle does nothing.
    @(negedge clk); abort = 1'b1;
    repeat (2) @(negedge clk);
    check(busy == 1'b0, "idle_abort_busy", busy, 0);
    abort = 1'b0;

    // Start pulse with new parameters mid-run is ignored.
    do_move(1'b0, 3, 2, -1, -1, 1'b1);
    check(remaining == '0, "ign_start_remaining", remaining, 0);

    // Reset after two steps, then an immediate fresh move.
    do_move(1'b1, 5, 2, -1, 2, 1'b0);
    do_move(1'b1, 2, 1, -1, -1, 1'b0);
    check(phase == 4'd2, "post_reset_phase", phase, 2);

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
